// File: rtl/object_plotter_if.sv
// object_plotter_if
//   Groups the request and pixel signals between the game-logic stage (master)
//   and the object plotter (slave).
//   Request side : startPlot, object, newX/newY, oldX/oldY, sizeX/sizeY
//   Pixel side   : vga_x, vga_y, vga_colour, vga_plot
//   Status side  : busy, done
interface object_plotter_if;
   logic       startPlot;
   logic [1:0] object;
   logic [7:0] newX;
   logic [6:0] newY;
   logic [7:0] oldX;
   logic [6:0] oldY;
   logic [7:0] sizeX;
   logic [6:0] sizeY;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;

   modport master (
      output startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
      input  vga_x, vga_y, vga_colour, vga_plot, busy, done
   );

   modport slave (
      input  startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
      output vga_x, vga_y, vga_colour, vga_plot, busy, done
   );
endinterface

// File: rtl/object_plotter.sv
// object_plotter
//   Rasterises one object update per startPlot request, one pixel per clock.
//   Ball/paddle: erase old rectangle, then draw new one. Brick: erase only.
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high reset
//     bus   - object_plotter_if.slave (request in, pixel stream and status out)
//
//   state  | meaning
//   IDLE   | waiting for startPlot
//   ERASE  | emitting background pixels over the erase rectangle
//   DRAW   | emitting object-coloured pixels over the new rectangle
//   FINISH | one-cycle done pulse, then back to IDLE
module object_plotter #(
   parameter logic [8:0] MAX_X         = 9'd159,
   parameter logic [7:0] MAX_Y         = 8'd119,
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter logic [2:0] BALL_COLOUR   = 3'b111,
   parameter logic [2:0] PADDLE_COLOUR = 3'b010,
   parameter logic [1:0] BALL_OBJ      = 2'b00,
   parameter logic [1:0] PADDLE_OBJ    = 2'b01,
   parameter logic [1:0] BLOCK_OBJ     = 2'b10,
   parameter logic [1:0] NO_OBJ        = 2'b11
) (
   input logic              clk,
   input logic              reset,
   object_plotter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

   state_t     state, stateNext;
   logic [7:0] xo, xoNext;
   logic [6:0] yo, yoNext;
   logic [1:0] objReg;
   logic [7:0] newXReg, oldXReg, sizeXReg;
   logic [6:0] newYReg, oldYReg, sizeYReg;

   // State and counters describe the pixel currently on the outputs; the
   // output registers are loaded with the pixel of the next state/counters so
   // the first pixel appears in the cycle right after the capture edge.
   logic       capture;
   logic [1:0] selObj;
   logic [7:0] srcNewX, srcOldX, originX;
   logic [6:0] srcNewY, srcOldY, originY;
   logic [8:0] sumX;
   logic [7:0] sumY;
   logic [2:0] colourNext;
   logic       pixelNext;

   assign capture = (state == IDLE) && bus.startPlot;

   always_comb begin
      stateNext = state;
      xoNext    = xo;
      yoNext    = yo;
      case (state)
         IDLE: begin
            if (bus.startPlot) begin
               xoNext = 8'd0;
               yoNext = 7'd0;
               if (bus.object == NO_OBJ || bus.sizeX == 8'd0 || bus.sizeY == 7'd0)
                  stateNext = FINISH;
               else
                  stateNext = ERASE;
            end
         end
         ERASE, DRAW: begin
            if (xo == sizeXReg - 8'd1) begin
               xoNext = 8'd0;
               if (yo == sizeYReg - 7'd1) begin
                  yoNext = 7'd0;
                  if (state == ERASE && objReg != BLOCK_OBJ)
                     stateNext = DRAW;
                  else
                     stateNext = FINISH;
               end else begin
                  yoNext = yo + 7'd1;
               end
            end else begin
               xoNext = xo + 8'd1;
            end
         end
         FINISH: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // On the capture edge the registered copies are not yet valid, so the
   // first pixel is built straight from the request inputs.
   always_comb begin
      selObj  = capture ? bus.object : objReg;
      srcNewX = capture ? bus.newX   : newXReg;
      srcNewY = capture ? bus.newY   : newYReg;
      srcOldX = capture ? bus.oldX   : oldXReg;
      srcOldY = capture ? bus.oldY   : oldYReg;
      if (stateNext == DRAW || selObj == BLOCK_OBJ) begin
         originX = srcNewX;
         originY = srcNewY;
      end else begin
         originX = srcOldX;
         originY = srcOldY;
      end
      sumX = {1'b0, originX} + {1'b0, xoNext};
      sumY = {1'b0, originY} + {1'b0, yoNext};
      if (stateNext == ERASE)
         colourNext = BG_COLOUR;
      else if (selObj == BALL_OBJ)
         colourNext = BALL_COLOUR;
      else if (selObj == PADDLE_OBJ)
         colourNext = PADDLE_COLOUR;
      else
         colourNext = BG_COLOUR;
      pixelNext = (stateNext == ERASE) || (stateNext == DRAW);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         xo             <= 8'd0;
         yo             <= 7'd0;
         objReg         <= 2'd0;
         newXReg        <= 8'd0;
         newYReg        <= 7'd0;
         oldXReg        <= 8'd0;
         oldYReg        <= 7'd0;
         sizeXReg       <= 8'd0;
         sizeYReg       <= 7'd0;
         bus.vga_x      <= 8'd0;
         bus.vga_y      <= 7'd0;
         bus.vga_colour <= 3'd0;
         bus.vga_plot   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         state <= stateNext;
         xo    <= xoNext;
         yo    <= yoNext;
         if (capture) begin
            objReg   <= bus.object;
            newXReg  <= bus.newX;
            newYReg  <= bus.newY;
            oldXReg  <= bus.oldX;
            oldYReg  <= bus.oldY;
            sizeXReg <= bus.sizeX;
            sizeYReg <= bus.sizeY;
         end
         if (pixelNext) begin
            bus.vga_x      <= sumX[7:0];
            bus.vga_y      <= sumY[6:0];
            bus.vga_colour <= colourNext;
         end
         // Off-screen pixels still take their cycle but are never written.
         bus.vga_plot <= pixelNext && (sumX <= MAX_X) && (sumY <= MAX_Y);
         bus.busy     <= pixelNext;
         bus.done     <= (stateNext == FINISH);
      end
   end

endmodule

// File: tb/tb_object_plotter.sv
module tb_object_plotter;
   logic clk = 1'b0;
   logic reset;
   int   nChecks = 0;
   int   nFails  = 0;
   logic [18:0] expQ[$];   // {plot, x[7:0], y[6:0], colour[2:0]} per pixel cycle

   object_plotter_if bus ();

   object_plotter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input int obs, input int exp);
      nChecks++;
      if (obs != exp) begin
         nFails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: list every pixel cycle of a request in scan order.
   task automatic addPhase(input int ox, input int oy, input int w, input int h,
                           input logic [2:0] col);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            int px = ox + c;
            int py = oy + r;
            logic onScreen = (px <= 159) && (py <= 119);
            expQ.push_back({onScreen, px[7:0], py[6:0], col});
         end
   endtask

   task automatic buildExp(input int obj, input int nx, input int ny, input int ox,
                           input int oy, input int sx, input int sy);
      expQ.delete();
      if (obj == 3 || sx == 0 || sy == 0) return;
      if (obj == 2) begin
         addPhase(nx, ny, sx, sy, 3'b000);
      end else begin
         addPhase(ox, oy, sx, sy, 3'b000);
         addPhase(nx, ny, sx, sy, (obj == 0) ? 3'b111 : 3'b010);
      end
   endtask

   task automatic scrambleInputs();
      bus.object = 2'($urandom);
      bus.newX   = 8'($urandom);
      bus.newY   = 7'($urandom);
      bus.oldX   = 8'($urandom);
      bus.oldY   = 7'($urandom);
      bus.sizeX  = 8'($urandom);
      bus.sizeY  = 7'($urandom);
   endtask

   task automatic runReq(input int obj, input int nx, input int ny, input int ox,
                         input int oy, input int sx, input int sy, input int injectAt);
      int n;
      buildExp(obj, nx, ny, ox, oy, sx, sy);
      n = expQ.size();
      @(negedge clk);
      bus.object = 2'(obj);
      bus.newX = 8'(nx); bus.newY = 7'(ny);
      bus.oldX = 8'(ox); bus.oldY = 7'(oy);
      bus.sizeX = 8'(sx); bus.sizeY = 7'(sy);
      bus.startPlot = 1'b1;
      @(posedge clk);
      #1;
      bus.startPlot = 1'b0;
      scrambleInputs();
      for (int k = 1; k <= n + 1; k++) begin
         @(negedge clk);
         bus.startPlot = (k == injectAt) && (injectAt < n);
         if (bus.startPlot) scrambleInputs();
         if (k <= n) begin
            logic [18:0] e = expQ[k-1];
            checkVal("plot",   bus.vga_plot,   e[18]);
            checkVal("x",      bus.vga_x,      e[17:10]);
            checkVal("y",      bus.vga_y,      e[9:3]);
            checkVal("colour", bus.vga_colour, e[2:0]);
            checkVal("busy",   bus.busy,       1);
            checkVal("done",   bus.done,       0);
         end else begin
            checkVal("doneEnd",  bus.done,     1);
            checkVal("busyEnd",  bus.busy,     0);
            checkVal("plotEnd",  bus.vga_plot, 0);
         end
      end
      @(negedge clk);
      bus.startPlot = 1'b0;
      checkVal("doneAfter", bus.done,     0);
      checkVal("plotAfter", bus.vga_plot, 0);
      checkVal("busyAfter", bus.busy,     0);
   endtask

   initial begin
      reset = 1'b1;
      bus.startPlot = 1'b0;
      scrambleInputs();
      #12;
      checkVal("rstX",      bus.vga_x,      0);
      checkVal("rstY",      bus.vga_y,      0);
      checkVal("rstColour", bus.vga_colour, 0);
      checkVal("rstPlot",   bus.vga_plot,   0);
      checkVal("rstBusy",   bus.busy,       0);
      checkVal("rstDone",   bus.done,       0);
      @(negedge clk);
      reset = 1'b0;

      runReq(0, 11, 19, 10, 20, 4, 4, 0);       // ball
      runReq(1, 99, 117, 100, 117, 20, 1, 0);   // paddle
      runReq(2, 16, 10, 0, 0, 16, 10, 0);       // brick
      runReq(0, 158, 118, 157, 117, 4, 4, 0);   // clipping
      runReq(0, 30, 40, 31, 41, 3, 3, 5);       // ignored second strobe
      runReq(3, 5, 5, 5, 5, 4, 4, 0);           // nothing to draw
      runReq(0, 5, 5, 5, 5, 0, 4, 0);           // zero width
      runReq(1, 5, 5, 5, 5, 4, 0, 0);           // zero height

      // Reset in the middle of DRAW.
      @(negedge clk);
      bus.object = 2'd0; bus.newX = 8'd50; bus.newY = 7'd50;
      bus.oldX = 8'd52; bus.oldY = 7'd51; bus.sizeX = 8'd5; bus.sizeY = 7'd5;
      bus.startPlot = 1'b1;
      @(negedge clk);
      bus.startPlot = 1'b0;
      repeat (30) @(negedge clk);
      checkVal("preRstBusy", bus.busy, 1);
      reset = 1'b1;
      #1;
      checkVal("midRstX",      bus.vga_x,      0);
      checkVal("midRstY",      bus.vga_y,      0);
      checkVal("midRstColour", bus.vga_colour, 0);
      checkVal("midRstPlot",   bus.vga_plot,   0);
      checkVal("midRstBusy",   bus.busy,       0);
      checkVal("midRstDone",   bus.done,       0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         checkVal("postRstDone", bus.done,     0);
         checkVal("postRstPlot", bus.vga_plot, 0);
      end
      runReq(0, 11, 19, 10, 20, 4, 4, 0);

      for (int t = 0; t < 40; t++) begin
         int obj = int'($urandom_range(0, 3));
         int nx  = int'($urandom_range(0, 255));
         int ny  = int'($urandom_range(0, 127));
         int ox  = int'($urandom_range(0, 255));
         int oy  = int'($urandom_range(0, 127));
         int sx  = int'($urandom_range(0, 10));
         int sy  = int'($urandom_range(0, 10));
         int inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0;
         runReq(obj, nx, ny, ox, oy, sx, sy, inj);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
